// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT sink-side framing path.
// Beat layout matches what the frame source pushes through its skid buffer.
package fft_pkg;

  localparam int DATA_W = 16;
  localparam int PTS_W  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic              sop;
    logic              eop;
    logic [PTS_W-1:0]  fftpts;
    logic              inverse;
  } beat_t;

  // Legal point counts are 2^k for 1 <= k <= PTS_W-1.
  function automatic logic pts_legal(input logic [PTS_W-1:0] n);
    logic ok;
    ok = 1'b0;
    for (int k = 1; k < PTS_W; k++) begin
      if (n == PTS_W'(1 << k)) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/fft_frame_src_if.sv
// Upstream sample stream and FFT sink stream of the frame source.
// master = the frame source itself, slave = its environment.
interface fft_frame_src_if #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int PTS_W  = fft_pkg::PTS_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_real;
  logic [DATA_W-1:0] in_imag;

  logic              fft_valid;
  logic              fft_ready;
  logic              fft_sop;
  logic              fft_eop;
  logic [DATA_W-1:0] fft_real;
  logic [DATA_W-1:0] fft_imag;
  logic [PTS_W-1:0]  fft_fftpts;
  logic              fft_inverse;
  logic [1:0]        fft_error;

  modport master (
    input  in_valid, in_real, in_imag, fft_ready,
    output in_ready, fft_valid, fft_sop, fft_eop, fft_real, fft_imag,
           fft_fftpts, fft_inverse, fft_error
  );

  modport slave (
    output in_valid, in_real, in_imag, fft_ready,
    input  in_ready, fft_valid, fft_sop, fft_eop, fft_real, fft_imag,
           fft_fftpts, fft_inverse, fft_error
  );

endinterface

// File: rtl/fft_skid_buf.sv
// Two-entry valid/ready skid buffer; 1-cycle latency when empty, outputs registered.
// in_rdy comes only from the occupancy register, so out_rdy never reaches in_rdy combinationally.
module fft_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic         empty
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   cnt_q;
  logic         push;
  logic         pop;

  assign in_rdy  = (cnt_q != 2'd2);
  assign out_vld = (cnt_q != 2'd0);
  assign out_dat = head_q;
  assign empty   = (cnt_q == 2'd0);

  assign push = in_vld && in_rdy;
  assign pop  = out_vld && out_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= in_dat;
          else               tail_q <= in_dat;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        // Push and pop together only happens with exactly one entry held.
        2'b11:   head_q <= in_dat;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_src.sv
// Cuts an unframed complex sample stream into N-point Avalon-ST frames for the FFT sink.
// 1-cycle latency into an empty buffer; in_ready drops when the 2-entry buffer is full or when idle.
module fft_frame_src #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int PTS_W  = fft_pkg::PTS_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [PTS_W-1:0]  cfg_fftpts,
  input  logic              cfg_inverse,
  fft_frame_src_if.master   bus,
  output logic              cfg_err,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  import fft_pkg::*;

  state_t           state_q;
  state_t           state_d;
  logic [PTS_W-1:0] cnt_q;
  logic [PTS_W-1:0] cnt_d;
  logic [PTS_W-1:0] n_q;
  logic [PTS_W-1:0] n_d;
  logic             inv_q;
  logic             inv_d;
  logic             cfg_err_d;

  logic             cfg_ok;
  logic             push;
  logic             last;
  logic             buf_in_rdy;
  logic             buf_out_vld;
  logic             buf_empty;
  logic [$bits(beat_t)-1:0] head_dat;
  beat_t            push_beat;
  beat_t            head_beat;

  assign cfg_ok       = pts_legal(cfg_fftpts);
  assign bus.in_ready = (state_q == ST_RUN) && buf_in_rdy;
  assign push         = bus.in_valid && bus.in_ready;
  assign last         = (cnt_q == n_q - PTS_W'(1));

  always_comb begin
    push_beat         = '0;
    push_beat.re      = bus.in_real;
    push_beat.im      = bus.in_imag;
    push_beat.sop     = (cnt_q == '0);
    push_beat.eop     = last;
    push_beat.fftpts  = n_q;
    push_beat.inverse = inv_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      inv_q   <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      inv_q   <= inv_d;
      cfg_err <= cfg_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    inv_d     = inv_q;
    cfg_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          if (cfg_ok) begin
            state_d = ST_RUN;
            n_d     = cfg_fftpts;
            inv_d   = cfg_inverse;
            cnt_d   = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (push) begin
          if (last) begin
            // Frame boundary: enable and cfg are only looked at here.
            cnt_d = '0;
            if (enable && cfg_ok) begin
              n_d   = cfg_fftpts;
              inv_d = cfg_inverse;
            end else begin
              state_d   = ST_IDLE;
              cfg_err_d = enable;
            end
          end else begin
            cnt_d = cnt_q + PTS_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  fft_skid_buf #(
    .W($bits(beat_t))
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .in_vld  (push),
    .in_rdy  (buf_in_rdy),
    .in_dat  (push_beat),
    .out_vld (buf_out_vld),
    .out_rdy (bus.fft_ready),
    .out_dat (head_dat),
    .empty   (buf_empty)
  );

  assign head_beat       = beat_t'(head_dat);
  assign bus.fft_valid   = buf_out_vld;
  assign bus.fft_sop     = head_beat.sop;
  assign bus.fft_eop     = head_beat.eop;
  assign bus.fft_real    = head_beat.re;
  assign bus.fft_imag    = head_beat.im;
  assign bus.fft_fftpts  = head_beat.fftpts;
  assign bus.fft_inverse = head_beat.inverse;
  assign bus.fft_error   = 2'b00;

  assign busy = (state_q == ST_RUN) || !buf_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (bus.fft_valid && bus.fft_ready && head_beat.eop) begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fft_frame_src.sv
// Directed bench for fft_frame_src: framing, backpressure, cfg handling, enable drop, reset.
module tb_fft_frame_src;
  import fft_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  cfg_fftpts;
  logic        cfg_inverse;
  logic        cfg_err;
  logic        busy;
  logic [15:0] frame_cnt;

  fft_frame_src_if #(.DATA_W(16), .PTS_W(4)) bus ();

  fft_frame_src #(.DATA_W(16), .PTS_W(4), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cfg_fftpts  (cfg_fftpts),
    .cfg_inverse (cfg_inverse),
    .bus         (bus),
    .cfg_err     (cfg_err),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] samp_q[$];
  beat_t       got_q[$];
  beat_t       exp_q[$];
  int          cyc = 0, occ = 0, up_xfers = 0;
  int          viol_full = 0, viol_valid = 0, viol_stall = 0;
  int          t_up = -1, t_fv = -1, t_rdy = -1, t_last = -1, en_cyc = 0;
  int          rdy_mode = 2;
  bit          rdy_phase = 1'b0;
  bit          stall_pend = 1'b0;
  beat_t       stall_beat;
  int          err_n, bad_rdy, bad_vld, budget;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input int v, input bit sop, input bit eop, input int pts, input bit inv);
    beat_t b;
    b.re      = 16'(v);
    b.im      = 16'(v) ^ 16'hA5A5;
    b.sop     = sop;
    b.eop     = eop;
    b.fftpts  = 4'(pts);
    b.inverse = inv;
    return b;
  endfunction

  task automatic add_frame(input int first, input int n, input bit inv);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(first + i, i == 0, i == n - 1, n, inv));
  endtask

  task automatic push_samples(input int first, input int n);
    for (int i = 0; i < n; i++) samp_q.push_back(16'(first + i));
  endtask

  // One cycle: drive at negedge, then sample and update the occupancy model.
  task automatic step();
    beat_t cur;
    bit    up_x, dn_x;
    @(negedge clk);
    cyc++;
    if (samp_q.size() > 0) begin
      bus.in_valid = 1'b1;
      bus.in_real  = samp_q[0];
      bus.in_imag  = samp_q[0] ^ 16'hA5A5;
    end else begin
      bus.in_valid = 1'b0;
      bus.in_real  = '0;
      bus.in_imag  = '0;
    end
    case (rdy_mode)
      0: bus.fft_ready = 1'b1;
      1: begin bus.fft_ready = rdy_phase; rdy_phase = ~rdy_phase; end
      default: bus.fft_ready = 1'b0;
    endcase
    #1;
    cur.re = bus.fft_real; cur.im = bus.fft_imag; cur.sop = bus.fft_sop;
    cur.eop = bus.fft_eop; cur.fftpts = bus.fft_fftpts; cur.inverse = bus.fft_inverse;
    up_x = bus.in_valid && bus.in_ready;
    dn_x = bus.fft_valid && bus.fft_ready;
    if (bus.in_ready && occ == 2) viol_full++;
    if (bus.fft_valid !== (occ > 0)) viol_valid++;
    if (stall_pend && cur !== stall_beat) viol_stall++;
    stall_pend = !reset && bus.fft_valid && !bus.fft_ready;
    stall_beat = cur;
    if (up_x) begin
      void'(samp_q.pop_front());
      up_xfers++;
      if (t_up < 0) t_up = cyc;
    end
    if (bus.in_ready && t_rdy < 0) t_rdy = cyc;
    if (bus.fft_valid && t_fv < 0) t_fv = cyc;
    if (dn_x) begin
      got_q.push_back(cur);
      t_last = cyc;
    end
    if (reset) occ = 0;
    else       occ = occ + int'(up_x) - int'(dn_x);
  endtask

  task automatic wait_beats(input int n, input int lim, input string tag);
    int k;
    k = 0;
    while (got_q.size() < n && k < lim) begin step(); k++; end
    chk(tag, 64'(got_q.size()), 64'(n));
  endtask

  task automatic wait_xfers(input int n, input string tag);
    int k;
    k = 0;
    while (up_xfers < n && k < 200) begin step(); k++; end
    chk(tag, 64'(up_xfers >= n), 64'd1);
  endtask

  task automatic cmp_frames(input string tag);
    chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("%s_b%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"},  64'(bus.in_ready),    64'd0);
    chk({tag, "_fft_valid"}, 64'(bus.fft_valid),   64'd0);
    chk({tag, "_sop_eop"},   64'({bus.fft_sop, bus.fft_eop}), 64'd0);
    chk({tag, "_data"},      64'({bus.fft_real, bus.fft_imag}), 64'd0);
    chk({tag, "_pts_inv"},   64'({bus.fft_fftpts, bus.fft_inverse}), 64'd0);
    chk({tag, "_error"},     64'(bus.fft_error),   64'd0);
    chk({tag, "_cfg_err"},   64'(cfg_err),         64'd0);
    chk({tag, "_busy"},      64'(busy),            64'd0);
    chk({tag, "_frame_cnt"}, 64'(frame_cnt),       64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; cfg_fftpts = 4'd0; cfg_inverse = 1'b0;
    bus.in_valid = 1'b0; bus.in_real = '0; bus.in_imag = '0; bus.fft_ready = 1'b0;
    repeat (3) step();
    chk_reset_vals("rst");
    reset = 1'b0;
    rdy_mode = 0;

    // Two back-to-back 8-point frames, fft_ready held high.
    cfg_fftpts = 4'd8; cfg_inverse = 1'b0;
    push_samples(0, 16);
    add_frame(0, 8, 1'b0); add_frame(8, 8, 1'b0);
    t_up = -1; t_fv = -1; t_rdy = -1;
    enable = 1'b1; en_cyc = cyc;
    wait_beats(16, 200, "t1_cnt");
    cmp_frames("t1");
    chk("t1_rdy_after_en", 64'(t_rdy - en_cyc), 64'd1);
    chk("t1_latency",      64'(t_fv - t_up),    64'd1);
    chk("t1_throughput",   64'(t_last - t_fv),  64'd15);
    step();
    chk("t1_frame_cnt", 64'(frame_cnt), 64'd2);

    // Same framing with fft_ready toggling.
    got_q.delete(); exp_q.delete();
    viol_full = 0; viol_valid = 0; viol_stall = 0;
    rdy_mode = 1;
    push_samples(16, 16);
    add_frame(16, 8, 1'b0); add_frame(24, 8, 1'b0);
    wait_beats(16, 400, "t2_cnt");
    cmp_frames("t2");
    chk("t2_rdy_when_full", 64'(viol_full),  64'd0);
    chk("t2_stall_stable",  64'(viol_stall), 64'd0);
    chk("t2_valid_vs_occ",  64'(viol_valid), 64'd0);
    rdy_mode = 0;
    repeat (2) step();
    chk("t2_frame_cnt", 64'(frame_cnt), 64'd4);

    // cfg change mid-frame takes effect only on the next frame.
    got_q.delete(); exp_q.delete(); up_xfers = 0;
    push_samples(32, 12);
    add_frame(32, 8, 1'b0); add_frame(40, 4, 1'b1);
    wait_xfers(3, "t3_x3");
    cfg_fftpts = 4'd4; cfg_inverse = 1'b1;
    wait_xfers(9, "t3_x9");
    cfg_fftpts = 4'd8; cfg_inverse = 1'b0;
    wait_beats(12, 200, "t3_cnt");
    cmp_frames("t3");
    repeat (2) step();
    chk("t3_frame_cnt", 64'(frame_cnt), 64'd6);

    // enable dropped mid-frame: frame completes, then idle.
    got_q.delete(); exp_q.delete(); up_xfers = 0;
    push_samples(44, 10);
    add_frame(44, 8, 1'b0);
    wait_xfers(2, "t5_x2");
    enable = 1'b0;
    wait_beats(8, 200, "t5_cnt");
    repeat (4) step();
    cmp_frames("t5");
    chk("t5_in_ready", 64'(bus.in_ready),  64'd0);
    chk("t5_busy",     64'(busy),          64'd0);
    chk("t5_left",     64'(samp_q.size()), 64'd2);
    chk("t5_frame_cnt", 64'(frame_cnt),    64'd7);

    // Illegal point count while idle, then a legal one.
    samp_q.delete(); got_q.delete(); exp_q.delete(); up_xfers = 0;
    push_samples(60, 4);
    add_frame(60, 4, 1'b0);
    cfg_fftpts = 4'd6; cfg_inverse = 1'b0; enable = 1'b1;
    err_n = 0; bad_rdy = 0; bad_vld = 0;
    repeat (5) begin
      step();
      err_n   += int'(cfg_err);
      bad_rdy += int'(bus.in_ready);
      bad_vld += int'(bus.fft_valid);
    end
    chk("t4_cfg_err_cycles", 64'(err_n),   64'd5);
    chk("t4_in_ready_idle",  64'(bad_rdy), 64'd0);
    chk("t4_fft_valid_idle", 64'(bad_vld), 64'd0);
    cfg_fftpts = 4'd4;
    step();
    chk("t4_cfg_err_clear", 64'(cfg_err), 64'd0);
    wait_xfers(1, "t4_x1");
    cfg_fftpts = 4'd8;
    wait_beats(4, 200, "t4_cnt");
    cmp_frames("t4");
    repeat (2) step();
    chk("t4_frame_cnt", 64'(frame_cnt), 64'd8);

    // Reset with a full buffer partway through an 8-point frame.
    got_q.delete(); exp_q.delete(); up_xfers = 0;
    push_samples(70, 8);
    wait_xfers(4, "t6_x4");
    rdy_mode = 2;
    budget = 0;
    while (occ != 2 && budget < 50) begin step(); budget++; end
    chk("t6_buf_full", 64'(occ), 64'd2);
    chk("t6_partial",  64'(up_xfers), 64'd5);
    reset = 1'b1; occ = 0; stall_pend = 1'b0;
    samp_q.delete();
    step();
    chk_reset_vals("t6_rst");
    reset = 1'b0;
    cfg_fftpts = 4'd4; cfg_inverse = 1'b1;
    got_q.delete(); exp_q.delete();
    push_samples(80, 4);
    add_frame(80, 4, 1'b1);
    rdy_mode = 0;
    wait_beats(4, 200, "t6_cnt");
    cmp_frames("t6");
    repeat (2) step();
    chk("t6_frame_cnt", 64'(frame_cnt), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_frame_src.md
# fft_frame_src

Avalon-ST frame transmitter for the FFT sink interface. Takes an unframed 16-bit complex sample stream and cuts it into N-point frames (N = configured point count). Drives valid/sop/eop/real/imag/fftpts/inverse/error toward the FFT core's sink port and honours its ready backpressure. Sits between the ADC/decimation path and the FFT core.

## Interface

Parameters
- DATA_W, 16, width of each real/imag sample
- PTS_W, 4, width of fftpts; legal N = 2^k for 1 ≤ k ≤ PTS_W-1 (default: 2, 4, 8)
- CNT_W, 16, width of frame_cnt

Ports
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- enable  in  1  permits new frames; sampled only at frame boundaries
- cfg_fftpts  in  PTS_W  requested point count N (value is N itself)
- cfg_inverse  in  1  1 = IFFT for the frame
- in_valid  in  1  upstream sample valid
- in_ready  out  1  upstream may transfer
- in_real, in_imag  in  DATA_W  upstream sample
- fft_valid  out  1  to FFT sink_valid
- fft_ready  in  1  from FFT sink_ready
- fft_sop, fft_eop  out  1  frame first/last beat
- fft_real, fft_imag  out  DATA_W  beat data
- fft_fftpts  out  PTS_W  per-frame N, constant across the frame
- fft_inverse  out  1  per-frame direction
- fft_error  out  2  tied 2'b00
- cfg_err  out  1  one-cycle pulse, illegal cfg_fftpts at frame start
- busy  out  1  high while in RUN or buffer non-empty
- frame_cnt  out  CNT_W  frames completed on the FFT side (eop handshakes), wraps

## Operation

- Handshakes: ready latency 0 on both sides. Transfer = valid && ready in the same cycle.
- FSM, states IDLE and RUN:
  - IDLE: in_ready = 0. When enable = 1, sample cfg. Legal N: latch N/inverse, clear sample counter, go to RUN. Illegal N: pulse cfg_err, stay IDLE, re-evaluate next cycle.
  - RUN: in_ready = buffer not full. Each upstream transfer pushes {data, sop = (cnt == 0), eop = (cnt == N-1), N, inverse} into the skid buffer, then cnt++.
  - On the upstream transfer with cnt == N-1, apply the same legality check to enable/cfg in that cycle:
    - enable && legal: relatch cfg, cnt = 0, stay RUN (back-to-back frames, no bubble).
    - enable && illegal: pulse cfg_err, go to IDLE.
    - !enable: go to IDLE.
- enable low mid-frame has no effect until eop.
- cfg changes mid-frame are ignored; the latched values ride with every beat.
- Skid buffer: 2 entries, registered outputs. The fft_* outputs come only from the buffer head.
- frame_cnt increments on each fft_valid && fft_ready && fft_eop, and wraps at 2^CNT_W.
- Reset clears the FSM to IDLE, empties the buffer, zeroes cnt/frame_cnt, and discards any partial frame. No fabricated eop is produced.

## Timing

- Reset values: in_ready 0, fft_valid 0, fft_sop 0, fft_eop 0, fft_real/imag 0, fft_fftpts 0, fft_inverse 0, fft_error 0, cfg_err 0, busy 0, frame_cnt 0.
- Latency: an upstream transfer in cycle t appears on fft_* in t+1 if the buffer was empty.
- Throughput: 1 beat/cycle sustained while fft_ready = 1.
- in_ready depends only on registered buffer state. There is no combinational path from fft_ready to in_ready.
- Buffer full: in_ready 0. Simultaneous push and pop when full is not possible, because in_ready is already 0.
- fft_valid, once high, holds with stable data until fft_ready.
- IDLE→RUN takes one cycle after enable is seen. The first in_ready is high in the cycle after the transition.

## Structure

- Shared package fft_pkg holds:
  - DATA_W/PTS_W defaults
  - beat struct {real, imag, sop, eop, fftpts, inverse}
  - function pts_legal(N), which returns 1 iff N is a power of two in range
- Sub-module fft_skid_buf: 2-entry valid/ready skid buffer, parameterised on payload width. It is reused by the FFT output-side sink.

## Test plan

- enable = 1, cfg_fftpts = 8, inverse = 0, 16 continuous samples 0..15, fft_ready = 1 → two frames. sop on samples 0 and 8, eop on 7 and 15, fft_fftpts = 8 on all beats, frame_cnt = 2, first fft_valid one cycle after the first transfer.
- Same stream with fft_ready toggling 1010… → no beat lost or duplicated, data stable while stalled, in_ready never high with the buffer full.
- cfg_fftpts changed from 8 to 4 (and inverse 0→1) at beat 3 of a frame → the current frame stays N = 8, inverse = 0. The next frame is 4 beats with fft_fftpts = 4, fft_inverse = 1.
- cfg_fftpts = 6 with enable = 1 in IDLE → cfg_err pulses each cycle, in_ready stays 0, fft_valid stays 0. Change to 4 → RUN, normal 4-point frames.
- enable dropped at beat 2 of an 8-point frame → the frame completes through eop, then IDLE with in_ready = 0 and busy = 0 after the buffer drains.
- reset asserted at beat 5 of a frame with the buffer holding 2 entries → next cycle all outputs are at reset values and frame_cnt = 0. After re-enable, the first beat carries sop.
